hdmi_audio_scheduler: RTL and testbench
=======================================

HDMI_AUDIO_SCHEDULER -- requirements
Module: hdmi_audio_scheduler

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27000000, meaning the clk_pixel frequency in Hz.
REQ-002 SHALL have parameter AUDIO_RATE, default 44100, meaning the output sample rate in Hz.
REQ-003 SHALL have parameter AUDIO_BIT_WIDTH, default 16, meaning the signed sample width.
REQ-004 SHALL have parameter NUM_SOURCES, default 3, meaning the number of mixed requesters.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk_pixel  in  1  sole clock; reset_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port enable  in  1  audio requested by the host.
REQ-007 SHALL have port src_valid  in  NUM_SOURCES  per-source sample available.
REQ-008 SHALL have port src_left, src_right  in  NUM_SOURCES x AUDIO_BIT_WIDTH  signed per-source samples.
REQ-009 SHALL have port src_ready  out  NUM_SOURCES  one-hot poll strobe.
REQ-010 SHALL have port underrun_clear  in  1  clears the underrun flags.
REQ-011 SHALL have port clk_audio  out  1  audio clock for the HDMI core, generated as a registered signal.
REQ-012 SHALL have port audio_sample_word  out  2 x AUDIO_BIT_WIDTH  [0]=left, [1]=right.
REQ-013 SHALL have port include_audio  out  1  audio-packet enable for the HDMI core.
REQ-014 SHALL have port underrun  out  NUM_SOURCES  sticky per-source missed-sample flags.
REQ-015 SHALL have port overrun  out  1  sticky flag, set when a tick is dropped.

Function
REQ-016 SHALL run an NCO with a 32-bit accumulator: add 2*AUDIO_RATE each cycle; when the sum is >= CLK_FREQ, subtract CLK_FREQ and emit a one-cycle half_tick.
REQ-017 SHALL toggle clk_audio on every half_tick; sample_tick SHALL be the half_tick on which clk_audio falls 1->0.
REQ-018 SHALL implement FSM states IDLE, COLLECT, SUM: IDLE->COLLECT on sample_tick with index=0; COLLECT advances the index each cycle; COLLECT->SUM after index NUM_SOURCES-1; SUM->IDLE.
REQ-019 In COLLECT with index i, SHALL assert src_ready[i] for exactly one cycle; all other src_ready bits SHALL be 0.
REQ-020 If src_valid[i]=1 in that cycle, SHALL capture src_left[i]/src_right[i]; otherwise SHALL use 0 and set underrun[i].
REQ-021 In SUM, SHALL add the captured samples sign-extended to AUDIO_BIT_WIDTH+$clog2(NUM_SOURCES)+1 bits and clamp to [-2^(W-1), 2^(W-1)-1].
REQ-022 SHALL update audio_sample_word on the SUM->IDLE edge, NUM_SOURCES+1 cycles after sample_tick, so it is stable at the next clk_audio rise.
REQ-023 SHALL drive audio_sample_word to 0 whenever include_audio=0.
REQ-024 SHALL raise include_audio at the first SUM completion with enable=1, and SHALL drop it at the first SUM completion with enable=0.
REQ-025 SHALL ignore a sample_tick arriving outside IDLE and set overrun.
REQ-026 underrun_clear SHALL zero underrun; a simultaneous set of the same bit SHALL win.
REQ-027 SHALL elaborate-time assert CLK_FREQ/(2*AUDIO_RATE) > NUM_SOURCES+2.

Reset
REQ-028 While reset_n=0 at a clk_pixel edge, SHALL set: accumulator 0, clk_audio 0, FSM IDLE, index 0, src_ready 0, audio_sample_word 0, include_audio 0, underrun 0, overrun 0.
REQ-029 A reset asserted mid-COLLECT SHALL abandon the partial mix with no output update, and outputs SHALL take reset values on the next edge.

Structure
REQ-030 SHALL place the FSM state enum and the saturating-add function in package hdmi_audio_pkg.
REQ-031 SHALL implement the fractional divider as sub-module audio_nco (inputs clk_pixel, reset_n; output half_tick).

Verification
REQ-032 CLK_FREQ=27000000, AUDIO_RATE=48000: half_tick intervals SHALL repeat 281,281,281,282 cycles, i.e. 1125 cycles per 4 half-ticks, and clk_audio period SHALL average 562.5 cycles.
REQ-033 With 3 sources all valid, left=0x7000 each -> left word 0x7FFF; right=0xA000 each -> right word 0x8000; left=0x0100, 0x0200, 0xFF00 -> left word 0x0200.
REQ-034 With src_valid[1]=0 and sources 0/2 at left=0x0010 -> left word 0x0020, underrun=3'b010; underrun_clear pulse -> underrun=0.
REQ-035 Raise enable -> include_audio=1 exactly NUM_SOURCES+1 cycles after the next sample_tick; drop enable -> include_audio=0 and word=0 after the following SUM.
REQ-036 Pull reset_n low in the COLLECT cycle with index=1 -> next edge: src_ready=0, word=0, clk_audio=0, FSM IDLE.
REQ-037 Force a sample_tick while in COLLECT -> overrun=1, and the word SHALL reflect only the original mix.

Source files
------------

// File: rtl/hdmi_audio_pkg.sv
// rtl/hdmi_audio_pkg.sv - shared FSM encoding and saturation helper for the HDMI audio scheduler
package hdmi_audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SUM     = 2'd2
    } sched_state_t;

    // Saturating adder output stage: clamps a wide signed sum into a width-bit signed range
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] sum, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/audio_nco.sv
// rtl/audio_nco.sv - fractional divider producing half-period ticks of the audio clock
module audio_nco #(
    parameter int CLK_FREQ   = 27000000,
    parameter int AUDIO_RATE = 44100
) (
    input  logic clk_pixel,
    input  logic reset_n,
    output logic half_tick
);

    localparam logic [31:0] STEP  = 32'(2 * AUDIO_RATE);
    localparam logic [31:0] LIMIT = 32'(CLK_FREQ);

    logic [31:0] acc;
    logic [31:0] sum;

    // Candidate accumulator value for this cycle
    always_comb begin
        sum = acc + STEP;
    end

    // Phase accumulator: wrap by CLK_FREQ and flag each wrap for one cycle
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            acc       <= '0;
            half_tick <= 1'b0;
        end else if (sum >= LIMIT) begin
            acc       <= sum - LIMIT;
            half_tick <= 1'b1;
        end else begin
            acc       <= sum;
            half_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/hdmi_audio_scheduler.sv
// rtl/hdmi_audio_scheduler.sv - polls audio sources once per sample, mixes with saturation, feeds the HDMI core
module hdmi_audio_scheduler
    import hdmi_audio_pkg::*;
#(
    parameter int CLK_FREQ        = 27000000,
    parameter int AUDIO_RATE      = 44100,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int NUM_SOURCES     = 3
) (
    input  logic                                        clk_pixel,
    input  logic                                        reset_n,
    input  logic                                        enable,
    input  logic [NUM_SOURCES-1:0]                      src_valid,
    input  logic [NUM_SOURCES-1:0][AUDIO_BIT_WIDTH-1:0] src_left,
    input  logic [NUM_SOURCES-1:0][AUDIO_BIT_WIDTH-1:0] src_right,
    output logic [NUM_SOURCES-1:0]                      src_ready,
    input  logic                                        underrun_clear,
    output logic                                        clk_audio,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0]             audio_sample_word,
    output logic                                        include_audio,
    output logic [NUM_SOURCES-1:0]                      underrun,
    output logic                                        overrun
);

    localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int SUM_W = AUDIO_BIT_WIDTH + $clog2(NUM_SOURCES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SOURCES - 1);

    // The whole poll-and-mix sequence must finish between two sample ticks
    if ((CLK_FREQ / (2 * AUDIO_RATE)) <= (NUM_SOURCES + 2)) begin : g_rate_check
        $error("hdmi_audio_scheduler: CLK_FREQ/(2*AUDIO_RATE) must exceed NUM_SOURCES+2");
    end

    sched_state_t state;
    sched_state_t state_next;
    logic [IDX_W-1:0] idx;
    logic half_tick;
    logic sample_tick;
    logic [NUM_SOURCES-1:0] underrun_set;
    logic signed [AUDIO_BIT_WIDTH-1:0] cap_l [NUM_SOURCES];
    logic signed [AUDIO_BIT_WIDTH-1:0] cap_r [NUM_SOURCES];
    logic signed [SUM_W-1:0] sum_l;
    logic signed [SUM_W-1:0] sum_r;
    logic [AUDIO_BIT_WIDTH-1:0] sat_l;
    logic [AUDIO_BIT_WIDTH-1:0] sat_r;

    audio_nco #(
        .CLK_FREQ   (CLK_FREQ),
        .AUDIO_RATE (AUDIO_RATE)
    ) u_nco (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .half_tick (half_tick)
    );

    // A sample starts on the half tick that brings clk_audio low
    assign sample_tick = half_tick & clk_audio;

    // Audio clock: toggles on every half tick
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            clk_audio <= 1'b0;
        end else if (half_tick) begin
            clk_audio <= ~clk_audio;
        end
    end

    // FSM state register
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (sample_tick) state_next = ST_COLLECT;
            ST_COLLECT: if (idx == LAST_IDX) state_next = ST_SUM;
            ST_SUM:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: one-hot poll strobe and the matching underrun set mask
    always_comb begin
        src_ready    = '0;
        underrun_set = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            src_ready[i]    = (state == ST_COLLECT) && (idx == IDX_W'(i));
            underrun_set[i] = src_ready[i] & ~src_valid[i];
        end
    end

    // Poll index and per-source capture; a missing sample is taken as silence
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            idx <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                cap_l[i] <= '0;
                cap_r[i] <= '0;
            end
        end else if (state == ST_IDLE) begin
            idx <= '0;
        end else if (state == ST_COLLECT) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (src_ready[i]) begin
                    cap_l[i] <= src_valid[i] ? src_left[i]  : '0;
                    cap_r[i] <= src_valid[i] ? src_right[i] : '0;
                end
            end
        end
    end

    // Wide sign-extended mix of the captured samples, then clamp to the output width
    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            sum_l = sum_l + {{(SUM_W - AUDIO_BIT_WIDTH){cap_l[i][AUDIO_BIT_WIDTH-1]}}, cap_l[i]};
            sum_r = sum_r + {{(SUM_W - AUDIO_BIT_WIDTH){cap_r[i][AUDIO_BIT_WIDTH-1]}}, cap_r[i]};
        end
        sat_l = AUDIO_BIT_WIDTH'(sat_add(64'(sum_l), AUDIO_BIT_WIDTH));
        sat_r = AUDIO_BIT_WIDTH'(sat_add(64'(sum_r), AUDIO_BIT_WIDTH));
    end

    // Output word and packet enable change only when a mix completes
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            audio_sample_word <= '0;
            include_audio     <= 1'b0;
        end else if (state == ST_SUM) begin
            include_audio        <= enable;
            audio_sample_word[0] <= enable ? sat_l : '0;
            audio_sample_word[1] <= enable ? sat_r : '0;
        end
    end

    // Sticky status: clear loses to a same-cycle set; ticks outside IDLE are dropped
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            underrun <= '0;
            overrun  <= 1'b0;
        end else begin
            underrun <= (underrun & ~{NUM_SOURCES{underrun_clear}}) | underrun_set;
            if (sample_tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_audio_scheduler.sv
// tb/tb_hdmi_audio_scheduler.sv - self-checking bench for hdmi_audio_scheduler
module tb_hdmi_audio_scheduler;

    localparam int W = 16;
    localparam int N = 3;

    logic clk_pixel = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic underrun_clear = 1'b0;
    logic [N-1:0] src_valid = '0;
    logic [N-1:0][W-1:0] src_left = '0;
    logic [N-1:0][W-1:0] src_right = '0;
    logic [N-1:0] src_ready;
    logic clk_audio;
    logic [1:0][W-1:0] audio_sample_word;
    logic include_audio;
    logic [N-1:0] underrun;
    logic overrun;

    hdmi_audio_scheduler #(
        .CLK_FREQ        (27000000),
        .AUDIO_RATE      (48000),
        .AUDIO_BIT_WIDTH (W),
        .NUM_SOURCES     (N)
    ) dut (
        .clk_pixel         (clk_pixel),
        .reset_n           (reset_n),
        .enable            (enable),
        .src_valid         (src_valid),
        .src_left          (src_left),
        .src_right         (src_right),
        .src_ready         (src_ready),
        .underrun_clear    (underrun_clear),
        .clk_audio         (clk_audio),
        .audio_sample_word (audio_sample_word),
        .include_audio     (include_audio),
        .underrun          (underrun),
        .overrun           (overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks = 0;
    int errors = 0;

    logic model_inc = 1'b0;
    logic [W-1:0] model_l = '0;
    logic [W-1:0] model_r = '0;

    typedef struct {
        logic [2:0]        valid;
        logic [2:0][15:0]  l;
        logic [2:0][15:0]  r;
        logic              en;
        logic [15:0]       exp_l;
        logic [15:0]       exp_r;
        logic [2:0]        exp_u;
        bit                mid_clear;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference mix: integer sum of the valid samples, clamped to the signed 16-bit range
    function automatic logic [15:0] mix_model(input logic [2:0] v, input logic [2:0][15:0] s);
        int acc;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            if (v[i]) acc += int'($signed(s[i]));
        end
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    task automatic wait_fall(output bit ok);
        logic prev;
        ok = 1'b0;
        prev = clk_audio;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_pixel);
            if (prev && !clk_audio) begin
                ok = 1'b1;
                break;
            end
            prev = clk_audio;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: no clk_audio fall within 1500 cycles");
        end
    endtask

    // One full sample: tick, three polls, sum, output update; optional mid-poll clear or forced extra tick
    task automatic run_mix(input logic [2:0] v, input logic [2:0][15:0] l, input logic [2:0][15:0] r,
                           input logic en, input logic [15:0] el, input logic [15:0] er,
                           input logic [2:0] eu, input bit mid_clear, input bit force_ov);
        bit ok;
        if (!mid_clear) begin
            @(negedge clk_pixel);
            underrun_clear = 1'b1;
            @(negedge clk_pixel);
            underrun_clear = 1'b0;
        end
        wait_fall(ok);
        if (!ok) return;
        src_valid = v;
        src_left  = l;
        src_right = r;
        enable    = en;
        if (!mid_clear) check("underrun_cleared", 32'(underrun), 32'd0);
        if (force_ov) begin
            check("overrun_before", 32'(overrun), 32'd0);
            force dut.u_nco.half_tick = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk_pixel);
            check($sformatf("src_ready_c%0d", c), 32'(src_ready), 32'(1 << c));
            if (c == 1 && mid_clear) underrun_clear = 1'b1;
            if (c == 2 && mid_clear) begin
                underrun_clear = 1'b0;
                check("underrun_set_wins", 32'(underrun), 32'(eu));
            end
            if (c == 2 && force_ov) begin
                force dut.u_nco.half_tick = 1'b0;
                check("overrun_set", 32'(overrun), 32'd1);
            end
        end
        @(negedge clk_pixel);
        if (force_ov) release dut.u_nco.half_tick;
        check("src_ready_sum", 32'(src_ready), 32'd0);
        check("include_hold", 32'(include_audio), 32'(model_inc));
        check("word_hold", {audio_sample_word[1], audio_sample_word[0]}, {model_r, model_l});
        @(negedge clk_pixel);
        check("include", 32'(include_audio), 32'(en));
        check("word_left", 32'(audio_sample_word[0]), 32'(el));
        check("word_right", 32'(audio_sample_word[1]), 32'(er));
        check("underrun", 32'(underrun), 32'(eu));
        @(negedge clk_pixel);
        check("src_ready_idle", 32'(src_ready), 32'd0);
        model_inc = en;
        model_l   = el;
        model_r   = er;
    endtask

    initial begin
        int t [10];
        int k;
        int cyc;
        logic prev;
        bit ok;
        logic [2:0] rv;
        logic [2:0][15:0] rl;
        logic [2:0][15:0] rr;
        logic ren;

        tbl[0] = '{3'b111, {16'h7000, 16'h7000, 16'h7000}, {16'hA000, 16'hA000, 16'hA000}, 1'b1, 16'h7FFF, 16'h8000, 3'b000, 1'b0};
        tbl[1] = '{3'b111, {16'hFF00, 16'h0200, 16'h0100}, {16'h0003, 16'h0002, 16'h0001}, 1'b1, 16'h0200, 16'h0006, 3'b000, 1'b0};
        tbl[2] = '{3'b110, {16'h0100, 16'h0100, 16'h7FFF}, {16'h0000, 16'h0000, 16'h0000}, 1'b1, 16'h0200, 16'h0000, 3'b001, 1'b0};
        tbl[3] = '{3'b101, {16'h0010, 16'h1234, 16'h0010}, {16'hFFFF, 16'h0005, 16'hFFFF}, 1'b1, 16'h0020, 16'hFFFE, 3'b010, 1'b1};
        tbl[4] = '{3'b000, {16'h1111, 16'h2222, 16'h3333}, {16'h4444, 16'h5555, 16'h6666}, 1'b1, 16'h0000, 16'h0000, 3'b111, 1'b0};
        tbl[5] = '{3'b111, {16'h8000, 16'h8000, 16'h8000}, {16'h0000, 16'h0001, 16'h7FFF}, 1'b1, 16'h8000, 16'h7FFF, 3'b000, 1'b0};
        tbl[6] = '{3'b111, {16'h0001, 16'h0001, 16'h0001}, {16'h0001, 16'h0001, 16'h0001}, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0};
        tbl[7] = '{3'b111, {16'h0003, 16'h0002, 16'h0001}, {16'hFFFD, 16'hFFFE, 16'hFFFF}, 1'b1, 16'h0006, 16'hFFFA, 3'b000, 1'b0};

        repeat (3) @(negedge clk_pixel);
        check("rst_src_ready", 32'(src_ready), 32'd0);
        check("rst_clk_audio", 32'(clk_audio), 32'd0);
        check("rst_word", {audio_sample_word[1], audio_sample_word[0]}, 32'd0);
        check("rst_include", 32'(include_audio), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;

        // Audio clock edge spacing: k-th half tick lands at ceil(k * 27e6 / 96000) cycles
        k = 0;
        cyc = 0;
        prev = clk_audio;
        while (k < 9 && cyc < 4000) begin
            @(negedge clk_pixel);
            cyc++;
            if (clk_audio !== prev) begin
                k++;
                t[k] = cyc;
            end
            prev = clk_audio;
        end
        if (k < 9) begin
            checks++;
            errors++;
            $display("FAIL nco_edges: saw %0d of 9 clk_audio edges", k);
        end else begin
            for (int j = 1; j < 9; j++) begin
                check($sformatf("half_tick_interval_%0d", j), 32'(t[j+1] - t[j]),
                      32'(((j + 1) * 1125 + 3) / 4 - (j * 1125 + 3) / 4));
            end
            check("four_half_ticks", 32'(t[5] - t[1]), 32'd1125);
            check("two_audio_periods", 32'(t[9] - t[1]), 32'd1125 * 2);
        end

        for (int i = 0; i < 8; i++) begin
            run_mix(tbl[i].valid, tbl[i].l, tbl[i].r, tbl[i].en, tbl[i].exp_l, tbl[i].exp_r,
                    tbl[i].exp_u, tbl[i].mid_clear, 1'b0);
        end

        // Extra tick forced mid-poll: must be dropped and flagged, mix unaffected
        run_mix(3'b011, {16'h7FFF, 16'h0010, 16'h0020}, {16'h0000, 16'h0001, 16'h0002}, 1'b1,
                16'h0030, 16'h0003, 3'b100, 1'b0, 1'b1);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset while polling source 1
        wait_fall(ok);
        if (ok) begin
            @(negedge clk_pixel);
            check("pre_reset_ready", 32'(src_ready), 32'b010);
            reset_n = 1'b0;
            @(negedge clk_pixel);
            check("mid_rst_src_ready", 32'(src_ready), 32'd0);
            check("mid_rst_word", {audio_sample_word[1], audio_sample_word[0]}, 32'd0);
            check("mid_rst_clk_audio", 32'(clk_audio), 32'd0);
            check("mid_rst_include", 32'(include_audio), 32'd0);
            check("mid_rst_overrun", 32'(overrun), 32'd0);
            check("mid_rst_underrun", 32'(underrun), 32'd0);
            @(negedge clk_pixel);
            reset_n = 1'b1;
            model_inc = 1'b0;
            model_l = '0;
            model_r = '0;
            repeat (5) @(negedge clk_pixel);
            check("post_rst_idle", 32'(src_ready), 32'd0);
            check("post_rst_word", {audio_sample_word[1], audio_sample_word[0]}, 32'd0);
        end

        for (int i = 0; i < 12; i++) begin
            rv  = 3'($urandom_range(0, 7));
            rl  = {16'($urandom), 16'($urandom), 16'($urandom)};
            rr  = {16'($urandom), 16'($urandom), 16'($urandom)};
            ren = ($urandom_range(0, 3) != 0);
            run_mix(rv, rl, rr, ren, ren ? mix_model(rv, rl) : 16'h0, ren ? mix_model(rv, rr) : 16'h0,
                    ~rv, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
